// File: rtl/trackball_emu.sv
// Joystick-to-trackball emulator: per-axis position counters with time-based acceleration.
// Optional quadrature outputs are enabled by defining TRACKBALL_QUAD_EN.
module trackball_emu #(
  parameter int unsigned AXES      = 2,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned TICK_DIV  = 12000,
  parameter int unsigned ACC_TICKS = 8,
  parameter int unsigned MAX_STEP  = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [AXES-1:0]       joy_pos,
  input  logic [AXES-1:0]       joy_neg,
  input  logic [1:0]            speed,
  output logic [AXES*CNT_W-1:0] cnt_o,
  output logic [AXES-1:0]       dir_o,
  output logic                  tick_o
`ifdef TRACKBALL_QUAD_EN
  ,
  output logic [AXES-1:0]       quad_a_o,
  output logic [AXES-1:0]       quad_b_o
`endif
);

  localparam int unsigned V_W = $clog2(MAX_STEP + 1);
  localparam int unsigned H_W = $clog2(ACC_TICKS + 1);

  typedef enum logic {StIdle, StMove} state_e;

  logic [DIV_W-1:0] r_div;
  logic             w_wrap;
  logic             w_tick;
  logic [V_W-1:0]   w_vmax;

  assign w_wrap = (r_div == DIV_W'(TICK_DIV - 1));
  assign w_tick = ce & w_wrap;
  assign tick_o = w_tick & ~reset;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (ce) begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
    end
  end

  // Velocity ceiling: 1/2/4/8 by speed, never above MAX_STEP
  always_comb begin
    w_vmax = V_W'(MAX_STEP);
    if ((32'd1 << speed) < MAX_STEP) w_vmax = V_W'(32'd1 << speed);
  end

  for (genvar k = 0; k < AXES; k++) begin : g_axis
    state_e           r_state, w_state_nxt;
    logic [V_W-1:0]   r_v, w_v_nxt, w_veff, w_step;
    logic [H_W-1:0]   r_hold, w_hold_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_dir, w_dir_nxt;
    logic             w_req;
    logic             w_neg;

    assign w_req  = joy_pos[k] ^ joy_neg[k];
    assign w_neg  = joy_neg[k];
    assign w_veff = (r_v > w_vmax) ? w_vmax : r_v;

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_state <= StIdle;
        r_v     <= V_W'(1);
        r_hold  <= '0;
        r_cnt   <= '0;
        r_dir   <= 1'b0;
      end else if (w_tick) begin
        r_state <= w_state_nxt;
        r_v     <= w_v_nxt;
        r_hold  <= w_hold_nxt;
        r_cnt   <= w_cnt_nxt;
        r_dir   <= w_dir_nxt;
      end
    end

    always_comb begin
      w_state_nxt = w_req ? StMove : StIdle;
    end

    // A fresh start or a reversal restarts at unit speed with one tick of hold credited
    always_comb begin
      w_step     = '0;
      w_v_nxt    = V_W'(1);
      w_hold_nxt = '0;
      w_dir_nxt  = r_dir;
      if (w_req) begin
        if (r_state == StMove && w_neg == r_dir) begin
          w_step = w_veff;
          if (r_hold == H_W'(ACC_TICKS - 1)) begin
            w_hold_nxt = '0;
            w_v_nxt    = (w_veff < w_vmax) ? w_veff + 1'b1 : w_vmax;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
            w_v_nxt    = w_veff;
          end
        end else begin
          w_step     = V_W'(1);
          w_hold_nxt = H_W'(1);
          w_dir_nxt  = w_neg;
        end
      end
      w_cnt_nxt = w_neg ? r_cnt - CNT_W'(w_step) : r_cnt + CNT_W'(w_step);
    end

    assign cnt_o[k*CNT_W +: CNT_W] = r_cnt;
    assign dir_o[k]                = r_dir;

`ifdef TRACKBALL_QUAD_EN
    localparam int P_W   = CNT_W + 2;
    localparam int P_MAX = (2 ** (P_W - 1)) - 1;
    localparam int P_MIN = -(2 ** (P_W - 1));

    logic signed [P_W-1:0] r_pend, w_pend_nxt;
    logic [1:0]            r_phase;
    int                    w_acc;

    // Drain one unit per ce cycle, add this tick's step, then saturate
    always_comb begin
      w_acc = int'(r_pend);
      if (ce && r_pend != '0) w_acc = r_pend[P_W-1] ? w_acc + 1 : w_acc - 1;
      if (w_tick) w_acc = w_neg ? w_acc - int'(w_step) : w_acc + int'(w_step);
      if (w_acc > P_MAX) w_acc = P_MAX;
      if (w_acc < P_MIN) w_acc = P_MIN;
      w_pend_nxt = P_W'(w_acc);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_pend  <= '0;
        r_phase <= 2'd0;
      end else if (ce) begin
        r_pend <= w_pend_nxt;
        if (r_pend != '0) r_phase <= r_pend[P_W-1] ? r_phase - 2'd1 : r_phase + 2'd1;
      end
    end

    assign quad_a_o[k] = r_phase[1];
    assign quad_b_o[k] = r_phase[1] ^ r_phase[0];
`endif
  end

endmodule

// File: tb/tb_trackball_emu.sv
// Directed, table-driven bench for trackball_emu with TICK_DIV=4 and default widths.
module tb_trackball_emu;

  typedef struct {
    string      tag;
    logic [1:0] pos;
    logic [1:0] neg;
    logic [1:0] spd;
    logic [7:0] cnt;
    logic [1:0] dir;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b1;
  logic [1:0] joy_pos = 2'b00;
  logic [1:0] joy_neg = 2'b00;
  logic [1:0] speed = 2'd3;
  logic [7:0] cnt_o;
  logic [1:0] dir_o;
  logic       tick_o;
`ifdef TRACKBALL_QUAD_EN
  logic [1:0] quad_a;
  logic [1:0] quad_b;
`endif

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  trackball_emu #(.TICK_DIV(4)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .ce      (ce),
    .joy_pos (joy_pos),
    .joy_neg (joy_neg),
    .speed   (speed),
    .cnt_o   (cnt_o),
    .dir_o   (dir_o),
    .tick_o  (tick_o)
`ifdef TRACKBALL_QUAD_EN
    ,
    .quad_a_o(quad_a),
    .quad_b_o(quad_b)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic add(input string t, input logic [1:0] p, input logic [1:0] n,
                     input logic [1:0] s, input logic [7:0] c, input logic [1:0] d);
    vec_t v;
    v = '{t, p, n, s, c, d};
    tbl.push_back(v);
  endtask

  // Returns at posedge+1 just after the next tick edge
  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tick_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL tick_timeout: no tick_o in 50 cycles, want one");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] acc_exp [16];
    logic [7:0] pos9_a  [9];
    logic [7:0] pos9_b  [9];
    logic [1:0] quad_exp[3];
    int         n;
    int         seen;

    acc_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                8'h0A, 8'h0C, 8'h0E, 8'h00, 8'h02, 8'h04, 8'h06, 8'h08};
    pos9_a  = '{8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hF0, 8'hF2};
    pos9_b  = '{8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8, 8'hF9, 8'hFB};

    for (int i = 0; i < 16; i++) add("accel", 2'b01, 2'b00, 2'd3, acc_exp[i], 2'b00);
    for (int i = 0; i < 5; i++) add("conflict", 2'b10, 2'b10, 2'd3, 8'h08, 2'b00);
    add("release", 2'b00, 2'b00, 2'd3, 8'h08, 2'b00);
    add("neg_wrap", 2'b00, 2'b10, 2'd3, 8'hF8, 2'b10);
    add("idle1", 2'b00, 2'b00, 2'd3, 8'hF8, 2'b10);
    for (int i = 0; i < 9; i++) add("pos_to_v2", 2'b01, 2'b00, 2'd3, pos9_a[i], 2'b10);
    add("reverse", 2'b00, 2'b01, 2'd3, 8'hF1, 2'b11);
    add("idle2", 2'b00, 2'b00, 2'd3, 8'hF1, 2'b11);
    for (int i = 0; i < 9; i++) add("pos_again", 2'b01, 2'b00, 2'd3, pos9_b[i], 2'b10);
    add("clamp1", 2'b01, 2'b00, 2'd0, 8'hFC, 2'b10);
    add("clamp2", 2'b01, 2'b00, 2'd0, 8'hFD, 2'b10);

    // Reset state
    #12;
    check("rst_cnt", 32'(cnt_o), 32'h0);
    check("rst_dir", 32'(dir_o), 32'h0);
    check("rst_tick", 32'(tick_o), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      joy_pos = tbl[i].pos;
      joy_neg = tbl[i].neg;
      speed   = tbl[i].spd;
      wait_tick();
      check({tbl[i].tag, "_cnt"}, 32'(cnt_o), 32'(tbl[i].cnt));
      check({tbl[i].tag, "_dir"}, 32'(dir_o), 32'(tbl[i].dir));
    end

    // ce gating mid-move: freeze with prescaler at 2, resume, tick after two more ce cycles
    joy_pos = 2'b01;
    joy_neg = 2'b00;
    speed   = 2'd0;
    wait_tick();
    check("gate_pre_cnt", 32'(cnt_o), 32'hFE);
    @(posedge clk);
    @(posedge clk);
    #1 ce = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick_o) seen++;
      @(posedge clk);
    end
    #1;
    check("gate_no_tick", 32'(seen), 32'd0);
    check("gate_hold_cnt", 32'(cnt_o), 32'hFE);
    ce = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (tick_o) begin
        n = i;
        break;
      end
    end
    check("gate_resume_gap", 32'(n), 32'd2);
    @(posedge clk);
    #1;
    check("gate_post_cnt", 32'(cnt_o), 32'hFF);

    // Asynchronous reset between edges, then first tick latency
    #3 reset = 1'b1;
    #1;
    check("arst_cnt", 32'(cnt_o), 32'h0);
    check("arst_dir", 32'(dir_o), 32'h0);
    check("arst_tick", 32'(tick_o), 32'h0);
    joy_pos = 2'b00;
    @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (tick_o) begin
        n = i;
        break;
      end
    end
    check("first_tick_gap", 32'(n), 32'd4);
    @(posedge clk);
    #1;

`ifdef TRACKBALL_QUAD_EN
    quad_exp = '{2'b01, 2'b11, 2'b10};
    joy_pos  = 2'b01;
    speed    = 2'd3;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      @(posedge clk);
      #1;
      check("quad_pos", 32'({quad_a[0], quad_b[0]}), 32'(quad_exp[i]));
    end
    joy_pos = 2'b00;
    joy_neg = 2'b01;
    wait_tick();
    @(posedge clk);
    #1;
    check("quad_neg", 32'({quad_a[0], quad_b[0]}), 32'b11);
`else
    quad_exp = '{2'b00, 2'b00, 2'b00};
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
